// File: rtl/cdc_cmd_pkg.sv
// cdc_cmd_pkg
//   Shared constants for the usb_cdc command responder: protocol opcodes,
//   response codes, the identification address and the FSM state encoding.
package cdc_cmd_pkg;

    // Host opcodes
    localparam logic [7:0] CMD_WR  = 8'h57;  // 'W' addr data
    localparam logic [7:0] CMD_RD  = 8'h52;  // 'R' addr

    // Device responses
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    // Reading this address returns the block identification byte
    localparam logic [7:0] ADDR_ID = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GET_ADDR_W = 3'd1,
        ST_GET_ADDR_R = 3'd2,
        ST_GET_DATA   = 3'd3,
        ST_RESP       = 3'd4
    } state_e;

endpackage

// File: rtl/cdc_cmd_responder.sv
// cdc_cmd_responder
//   Application-side responder for the usb_cdc byte stream. Decodes
//   'W' addr data (write) and 'R' addr (read) commands from the OUT stream
//   and returns one response byte per command on the IN stream. Drives a
//   bank of N_REGS host-writable 8-bit registers.
//
// Ports
//   clk_i        single clock (usb_cdc app domain)
//   rstn_i       asynchronous active-low reset
//   out_data_i   host->device byte        out_valid_i / out_ready_o
//   in_data_o    device->host response    in_valid_o  / in_ready_i
//   regs_o       register bank, reg k at [8k+7:8k]
//   wr_stb_o     one-hot one-cycle pulse on a register write
//
// Handshake: on both streams a byte transfers at a rising clk_i edge where
// valid and ready are both high; the sender holds data stable while valid
// is high and ready is low. out_ready_o and in_valid_o are never both high.
//
// Build option
//   CMD_TIMEOUT_EN : when defined, a partial command that sees no byte for
//                    TIMEOUT_CYCLES cycles is silently dropped (back to IDLE,
//                    no response, no write). When undefined, a partial
//                    command waits indefinitely.
module cdc_cmd_responder
    import cdc_cmd_pkg::*;
#(
    parameter int         N_REGS  = 4,
    parameter logic [7:0] ID_BYTE = 8'hC5
`ifdef CMD_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 32'd4800000
`endif
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [7:0]            out_data_i,
    input  logic                  out_valid_i,
    output logic                  out_ready_o,
    output logic [7:0]            in_data_o,
    output logic                  in_valid_o,
    input  logic                  in_ready_i,
    output logic [8*N_REGS-1:0]   regs_o,
    output logic [N_REGS-1:0]     wr_stb_o
);

    // Full 8-bit address compare: no truncation to the register index width
    localparam logic [7:0] N_REGS_B = 8'(N_REGS);

    state_e                state_q, state_d;
    logic [7:0]            addr_q, addr_d;
    logic [7:0]            rsp_q, rsp_d;
    logic [8*N_REGS-1:0]   regs_q, regs_d;
    logic [N_REGS-1:0]     wr_stb_q, wr_stb_d;
    logic                  out_ready_q;
    logic                  in_valid_q;

    logic                  out_acc;
    logic                  in_acc;
    logic                  in_cmd;
    logic [7:0]            rd_val;

    assign out_acc = out_valid_i && out_ready_q;
    assign in_acc  = in_valid_q && in_ready_i;
    assign in_cmd  = (state_q == ST_GET_ADDR_W) || (state_q == ST_GET_ADDR_R) ||
                     (state_q == ST_GET_DATA);

`ifdef CMD_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_hit;

    // Only counts while a command is partially received and no byte arrives
    assign tmo_hit = in_cmd && !out_acc && (tmo_q == TMO_LAST);
    assign tmo_d   = (in_cmd && !out_acc && !tmo_hit) ? tmo_q + 1'b1 : '0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // Response for a read of the byte currently on out_data_i
    always_comb begin
        rd_val = (out_data_i == ADDR_ID) ? ID_BYTE : RSP_NAK;
        for (int k = 0; k < N_REGS; k++) begin
            if (out_data_i == 8'(k)) begin
                rd_val = regs_q[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rsp_d    = rsp_q;
        regs_d   = regs_q;
        wr_stb_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (out_acc) begin
                    if (out_data_i == CMD_WR) begin
                        state_d = ST_GET_ADDR_W;
                    end else if (out_data_i == CMD_RD) begin
                        state_d = ST_GET_ADDR_R;
                    end else begin
                        rsp_d   = RSP_NAK;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_GET_ADDR_W: begin
                if (out_acc) begin
                    addr_d  = out_data_i;
                    state_d = ST_GET_DATA;
                end
            end
            ST_GET_ADDR_R: begin
                if (out_acc) begin
                    rsp_d   = rd_val;
                    state_d = ST_RESP;
                end
            end
            ST_GET_DATA: begin
                if (out_acc) begin
                    rsp_d   = (addr_q < N_REGS_B) ? RSP_ACK : RSP_NAK;
                    state_d = ST_RESP;
                    for (int k = 0; k < N_REGS; k++) begin
                        if (addr_q == 8'(k)) begin
                            regs_d[8*k +: 8] = out_data_i;
                            wr_stb_d[k]      = 1'b1;
                        end
                    end
                end
            end
            ST_RESP: begin
                if (in_acc) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef CMD_TIMEOUT_EN
        if (tmo_hit) begin
            state_d = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rsp_q       <= '0;
            regs_q      <= '0;
            wr_stb_q    <= '0;
            out_ready_q <= 1'b0;
            in_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rsp_q       <= rsp_d;
            regs_q      <= regs_d;
            wr_stb_q    <= wr_stb_d;
            // Registered handshake flags derived from the next state
            out_ready_q <= (state_d != ST_RESP);
            in_valid_q  <= (state_d == ST_RESP);
        end
    end

    assign out_ready_o = out_ready_q;
    assign in_valid_o  = in_valid_q;
    assign in_data_o   = rsp_q;
    assign regs_o      = regs_q;
    assign wr_stb_o    = wr_stb_q;

endmodule

// File: tb/tb_cdc_cmd_responder.sv
// tb_cdc_cmd_responder
//   Self-checking bench for cdc_cmd_responder: directed protocol cases,
//   backpressure, reset mid-command, randomized command stream against a
//   register-array reference model, and (with CMD_TIMEOUT_EN) timeout cases.
module tb_cdc_cmd_responder;

    localparam int N_REGS = 4;
    localparam logic [7:0] ID_VAL = 8'hC5;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic                 clk = 1'b0;
    logic                 rstn;
    logic [7:0]           out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [8*N_REGS-1:0]  regs;
    logic [N_REGS-1:0]    wr_stb;

    always #5 clk = ~clk;

`ifdef CMD_TIMEOUT_EN
    cdc_cmd_responder #(.N_REGS(N_REGS), .ID_BYTE(ID_VAL), .TIMEOUT_CYCLES(16)) dut (
`else
    cdc_cmd_responder #(.N_REGS(N_REGS), .ID_BYTE(ID_VAL)) dut (
`endif
        .clk_i       (clk),
        .rstn_i      (rstn),
        .out_data_i  (out_data),
        .out_valid_i (out_valid),
        .out_ready_o (out_ready),
        .in_data_o   (in_data),
        .in_valid_o  (in_valid),
        .in_ready_i  (in_ready),
        .regs_o      (regs),
        .wr_stb_o    (wr_stb)
    );

    // ------------------------------------------------------------------
    // Scoreboard / reference model
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] mregs [N_REGS];
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8*N_REGS-1:0] model_vec();
        logic [8*N_REGS-1:0] v;
        v = '0;
        for (int k = 0; k < N_REGS; k++) v[8*k +: 8] = mregs[k];
        return v;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < N_REGS; k++) mregs[k] = 8'h00;
    endfunction

    // Applies one full command to the model; returns response and write strobe
    function automatic void model_exec(input logic [7:0] op, input logic [7:0] a,
                                       input logic [7:0] d, output logic [7:0] rsp,
                                       output logic [N_REGS-1:0] stb);
        stb = '0;
        if (op == 8'h57) begin
            if (int'(a) < N_REGS) begin
                mregs[int'(a)] = d;
                stb[int'(a)]   = 1'b1;
                rsp = 8'h06;
            end else begin
                rsp = 8'h15;
            end
        end else if (op == 8'h52) begin
            if (int'(a) < N_REGS) rsp = mregs[int'(a)];
            else if (a == 8'hFF)  rsp = ID_VAL;
            else                  rsp = 8'h15;
        end else begin
            rsp = 8'h15;
        end
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // Leaves the clock at #1 after the handshake edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        repeat (gap) @(posedge clk);
        @(negedge clk);
        out_data  = b;
        out_valid = 1'b1;
        k = 0;
        while (!out_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k == 100) chk("out_ready_wait", 64'(out_ready), 64'd1);
        @(posedge clk);
        #1;
        out_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int gap, input int stall);
        int n;
        logic [7:0] bytes [3];
        logic [7:0] rsp;
        logic [N_REGS-1:0] stb;
        n = (b0 == 8'h57) ? 3 : (b0 == 8'h52) ? 2 : 1;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        for (int i = 0; i < n; i++) begin
            send_byte(bytes[i], gap);
            if (i < n - 1) begin
                chk("mid_in_valid", 64'(in_valid), 64'd0);
                chk("mid_wr_stb", 64'(wr_stb), 64'd0);
            end
        end
        model_exec(b0, b1, b2, rsp, stb);
        exp_q.push_back(rsp);
        // Cycle after the final byte: response up, write applied, strobe pulsing
        chk("rsp_valid", 64'(in_valid), 64'd1);
        chk("rsp_out_ready", 64'(out_ready), 64'd0);
        chk("wr_stb", 64'(wr_stb), 64'(stb));
        chk("regs", 64'(regs), 64'(model_vec()));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 64'(in_valid), 64'd1);
            chk("stall_data", 64'(in_data), 64'(rsp));
            chk("stall_out_ready", 64'(out_ready), 64'd0);
            chk("stall_wr_stb", 64'(wr_stb), 64'd0);
        end
        in_ready = 1'b1;
        chk("rsp_data", 64'(in_data), 64'(exp_q.pop_front()));
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        chk("post_valid", 64'(in_valid), 64'd0);
        chk("post_out_ready", 64'(out_ready), 64'd1);
        chk("post_wr_stb", 64'(wr_stb), 64'd0);
        chk("post_regs", 64'(regs), 64'(model_vec()));
    endtask

    function automatic logic [7:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel <= 5)      return 8'($urandom_range(0, N_REGS + 1));
        else if (sel <= 7) return 8'hFF;
        else               return 8'($urandom_range(0, 255));
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] op;
        rstn      = 1'b0;
        out_data  = 8'h00;
        out_valid = 1'b0;
        in_ready  = 1'b0;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_regs", 64'(regs), 64'd0);
        chk("rst_wr_stb", 64'(wr_stb), 64'd0);
        chk("rst_in_valid", 64'(in_valid), 64'd0);
        chk("rst_in_data", 64'(in_data), 64'd0);
        chk("rst_out_ready", 64'(out_ready), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_out_ready", 64'(out_ready), 64'd1);

        // Directed protocol cases
        run_cmd(8'h57, 8'h02, 8'hA5, 0, 0);
        run_cmd(8'h52, 8'h02, 8'h00, 0, 0);
        run_cmd(8'h52, 8'hFF, 8'h00, 0, 1);
        run_cmd(8'h52, 8'h07, 8'h00, 1, 0);
        run_cmd(8'h41, 8'h00, 8'h00, 0, 0);
        run_cmd(8'h57, 8'h09, 8'h33, 0, 2);
        run_cmd(8'h57, 8'hFF, 8'h44, 0, 0);
        run_cmd(8'h57, 8'h03, 8'h3C, 0, 0);
        run_cmd(8'h52, 8'h03, 8'h00, 0, 0);
        // Backpressure: response held for 50 cycles
        run_cmd(8'h52, 8'h02, 8'h00, 0, 50);

        // Randomized command stream
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 4))
                0, 1: op = 8'h57;
                2, 3: op = 8'h52;
                default: begin
                    op = 8'($urandom_range(0, 255));
                    while (op == 8'h57 || op == 8'h52) op = 8'($urandom_range(0, 255));
                end
            endcase
            run_cmd(op, rand_addr(), 8'($urandom_range(0, 255)),
                    $urandom_range(0, 2), $urandom_range(0, 4));
        end

        // Reset in the middle of a command
        run_cmd(8'h57, 8'h01, 8'h5A, 0, 0);
        send_byte(8'h57, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        model_clear();
        chk("midrst_regs", 64'(regs), 64'd0);
        chk("midrst_in_valid", 64'(in_valid), 64'd0);
        chk("midrst_out_ready", 64'(out_ready), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_rel_ready", 64'(out_ready), 64'd1);
        run_cmd(8'h52, 8'h01, 8'h00, 0, 0);

`ifdef CMD_TIMEOUT_EN
        // Abandoned opcode times out; following read must not be eaten by it
        run_cmd(8'h57, 8'h00, 8'h6B, 0, 0);
        send_byte(8'h57, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("tmo_no_rsp", 64'(in_valid), 64'd0);
        end
        chk("tmo_regs", 64'(regs), 64'(model_vec()));
        run_cmd(8'h52, 8'h00, 8'h00, 0, 0);
        // 10-cycle gaps inside a command do not abort it
        run_cmd(8'h57, 8'h03, 8'h77, 10, 0);
        run_cmd(8'h52, 8'h03, 8'h00, 10, 0);
`endif

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
